// File: rtl/fall_manager.sv
// Falling-item game core: spawns items into free slots, moves them on fall ticks, and scores catches/misses.
// Optional macro FALL_SPEEDUP_EN: fall step grows with score (FALL_STEP + score/16, capped at 2*FALL_STEP).
module fall_manager #(
  parameter int N_ITEMS   = 4,
  parameter int SCREEN_H  = 480,
  parameter int ITEM_W    = 16,
  parameter int STACK_W   = 64,
  parameter int CATCH_Y   = 440,
  parameter int FALL_STEP = 4,
  parameter int SPAWN_GAP = 8,
  parameter int SCORE_W   = 8,
  parameter int MAX_MISS  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fall_tick,
  input  logic                   pause,
  input  logic [9:0]             stack_x,
  output logic [N_ITEMS*10-1:0]  items_x,
  output logic [N_ITEMS*10-1:0]  items_y,
  output logic [N_ITEMS*2-1:0]   items_clr,
  output logic [N_ITEMS-1:0]     items_act,
  output logic [SCORE_W-1:0]     score,
  output logic [1:0]             miss_cnt,
  output logic                   catch_pulse,
  output logic                   miss_pulse,
  output logic                   game_over
);

  localparam int unsigned NI       = N_ITEMS;
  localparam int          SPW      = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam logic [1:0]  MISS_SAT = 2'(MAX_MISS);
  localparam logic [10:0] CATCH_LN = 11'(CATCH_Y);
  localparam logic [10:0] MISS_LN  = 11'(SCREEN_H - ITEM_W);

  logic [15:0]        lfsr_q, lfsr_d;
  logic [SPW-1:0]     spawn_q, spawn_d;
  logic [NI-1:0]      act_q, act_d;
  logic [9:0]         x_q [NI];
  logic [9:0]         x_d [NI];
  logic [9:0]         y_q [NI];
  logic [9:0]         y_d [NI];
  logic [1:0]         clr_q [NI];
  logic [1:0]         clr_d [NI];
  logic [SCORE_W-1:0] score_q, score_d;
  logic [1:0]         miss_q, miss_d;
  logic               catch_q, catch_d;
  logic               missp_q, missp_d;
  logic               go_q, go_d;

  logic               tick;
  logic [9:0]         step;

  assign tick = fall_tick & ~pause & ~go_q;

`ifdef FALL_SPEEDUP_EN
  logic [SCORE_W+10:0] step_raw;
  always_comb begin
    step_raw = (SCORE_W+11)'(score_q >> 4) + (SCORE_W+11)'(FALL_STEP);
    if (step_raw > (SCORE_W+11)'(2*FALL_STEP)) begin
      step = 10'(2*FALL_STEP);
    end else begin
      step = step_raw[9:0];
    end
  end
`else
  assign step = 10'(FALL_STEP);
`endif

  logic [7:0]          n_catch;
  logic [7:0]          n_miss;
  logic                spawn_done;
  logic [10:0]         old_y;
  logic [10:0]         new_y;
  logic [10:0]         x_right;
  logic [10:0]         stack_right;
  logic [SCORE_W:0]    score_sum;
  logic [8:0]          miss_sum;

  always_comb begin
    lfsr_d      = lfsr_q;
    spawn_d     = spawn_q;
    act_d       = act_q;
    x_d         = x_q;
    y_d         = y_q;
    clr_d       = clr_q;
    score_d     = score_q;
    miss_d      = miss_q;
    catch_d     = 1'b0;
    missp_d     = 1'b0;
    go_d        = go_q | (miss_q == MISS_SAT);
    n_catch     = '0;
    n_miss      = '0;
    spawn_done  = 1'b0;
    old_y       = '0;
    new_y       = '0;
    x_right     = '0;
    stack_right = {1'b0, stack_x} + 11'(STACK_W);
    score_sum   = '0;
    miss_sum    = '0;

    if (!pause && !go_q) begin
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    if (tick) begin
      // Move and resolve only slots active before this tick; spawns below target inactive ones.
      for (int unsigned i = 0; i < NI; i++) begin
        if (act_q[i]) begin
          old_y   = {1'b0, y_q[i]};
          new_y   = old_y + {1'b0, step};
          x_right = {1'b0, x_q[i]} + 11'(ITEM_W);
          y_d[i]  = new_y[9:0];
          if (old_y < CATCH_LN && new_y >= CATCH_LN &&
              x_right > {1'b0, stack_x} && {1'b0, x_q[i]} < stack_right) begin
            act_d[i] = 1'b0;
            n_catch  = n_catch + 8'd1;
          end else if (new_y >= MISS_LN) begin
            act_d[i] = 1'b0;
            n_miss   = n_miss + 8'd1;
          end
        end
      end

      if (spawn_q == '0) begin
        spawn_d = SPW'(SPAWN_GAP - 1);
        for (int unsigned i = 0; i < NI; i++) begin
          if (!act_q[i] && !spawn_done) begin
            spawn_done = 1'b1;
            act_d[i]   = 1'b1;
            y_d[i]     = '0;
            x_d[i]     = 10'd64 + {1'b0, lfsr_q[8:0]};
            clr_d[i]   = lfsr_q[11:10];
          end
        end
      end else begin
        spawn_d = spawn_q - SPW'(1);
      end

      score_sum = {1'b0, score_q} + (SCORE_W+1)'(n_catch);
      score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
      miss_sum  = {7'd0, miss_q} + {1'b0, n_miss};
      miss_d    = (miss_sum >= 9'(MAX_MISS)) ? MISS_SAT : miss_sum[1:0];
      catch_d   = (n_catch != '0);
      missp_d   = (n_miss != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q  <= 16'hACE1;
      spawn_q <= '0;
      act_q   <= '0;
      x_q     <= '{default: '0};
      y_q     <= '{default: '0};
      clr_q   <= '{default: '0};
      score_q <= '0;
      miss_q  <= '0;
      catch_q <= 1'b0;
      missp_q <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      spawn_q <= spawn_d;
      act_q   <= act_d;
      x_q     <= x_d;
      y_q     <= y_d;
      clr_q   <= clr_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      catch_q <= catch_d;
      missp_q <= missp_d;
      go_q    <= go_d;
    end
  end

  for (genvar g = 0; g < N_ITEMS; g++) begin : g_out
    assign items_x[10*g +: 10]  = x_q[g];
    assign items_y[10*g +: 10]  = y_q[g];
    assign items_clr[2*g +: 2]  = clr_q[g];
  end

  assign items_act   = act_q;
  assign score       = score_q;
  assign miss_cnt    = miss_q;
  assign catch_pulse = catch_q;
  assign miss_pulse  = missp_q;
  assign game_over   = go_q;

endmodule

// File: doc/fall_manager.md
FALL_MANAGER -- requirements
Module: fall_manager

Interface
REQ-001 Parameter N_ITEMS, default 4, number of independent falling-item slots.
REQ-002 Parameter SCREEN_H, default 480, visible height in pixels.
REQ-003 Parameter ITEM_W, default 16, item square size in pixels.
REQ-004 Parameter STACK_W, default 64, catcher width in pixels.
REQ-005 Parameter CATCH_Y, default 440, item-top y at which catch is evaluated.
REQ-006 Parameter FALL_STEP, default 4, pixels moved per fall tick.
REQ-007 Parameter SPAWN_GAP, default 8, fall ticks between spawn attempts.
REQ-008 Parameter SCORE_W, default 8, score counter width; MAX_MISS, default 3, misses to game over.
REQ-009 clk  in  1  system clock; all state on rising edge.
REQ-010 rst  in  1  asynchronous, active-low reset.
REQ-011 fall_tick  in  1  one-clk pulse from clk_divider marking a fall step.
REQ-012 pause  in  1  level; freezes all game state while high.
REQ-013 stack_x  in  10  left x of catcher stack.
REQ-014 items_x / items_y  out  N_ITEMS*10 each  per-slot position, slot i at bits [10i+9:10i].
REQ-015 items_clr  out  N_ITEMS*2  per-slot color; items_act  out  N_ITEMS  slot-active flags.
REQ-016 score  out  SCORE_W; miss_cnt  out  2; catch_pulse, miss_pulse, game_over  out  1 each.

Function
REQ-017 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) SHALL advance every clk unless pause or game_over.
REQ-018 A tick is a clk cycle with fall_tick=1, pause=0, game_over=0; all other cycles SHALL leave slots, counters and score unchanged.
REQ-019 Spawn counter SHALL decrement per tick; at 0 it SHALL reload SPAWN_GAP-1 and attempt a spawn.
REQ-020 Spawn SHALL fill the lowest-index inactive slot: act=1, y=0, x=64+lfsr[8:0], clr=lfsr[11:10]; if all slots active the attempt SHALL be dropped.
REQ-021 On each tick every slot active before the tick SHALL add the step to y; a slot spawned that tick SHALL not move.
REQ-022 Catch: moved slot with old y<CATCH_Y, new y>=CATCH_Y, and x+ITEM_W>stack_x and x<stack_x+STACK_W SHALL deactivate.
REQ-023 Miss: uncaught slot with new y>=SCREEN_H-ITEM_W SHALL deactivate and increment miss_cnt.
REQ-024 Score SHALL add the number of catches in the tick, saturating at all-ones; catch_pulse SHALL be high one cycle if any catch.
REQ-025 miss_pulse SHALL be high one cycle if any miss; miss_cnt SHALL saturate at MAX_MISS.
REQ-026 game_over SHALL set the cycle after miss_cnt reaches MAX_MISS and hold until reset; slots stay visible, frozen.
REQ-027 All outputs SHALL be registered; effects of a tick SHALL appear on the cycle after fall_tick is sampled.
REQ-028 fall_tick arriving while pause=1 SHALL be discarded, not queued.
REQ-029 stack_x+STACK_W SHALL be computed 11 bits wide; no wrap in overlap compare.

Reset
REQ-030 rst low SHALL immediately clear items_act, items_x, items_y, items_clr, score, miss_cnt, pulses, game_over, and load spawn counter 0, LFSR 16'hACE1.
REQ-031 Reset asserted mid-tick SHALL win; first spawn occurs on the first tick after release.

Configuration
REQ-032 With FALL_SPEEDUP_EN defined, step SHALL be FALL_STEP+(score>>4), capped at 2*FALL_STEP; without it, step SHALL equal FALL_STEP.

Verification
REQ-033 Reset release, single tick -> slot0 act=1, y=0, x=64+lfsr[8:0]; other slots inactive.
REQ-034 Slot at x=100, stack_x=90, ticks until y crosses 440 -> act=0, score=1, catch_pulse one cycle.
REQ-035 Slot at x=300, stack_x=0 -> passes 440, deactivates at y>=464, miss_cnt=1, miss_pulse one cycle.
REQ-036 Three misses -> game_over=1 next cycle; further ticks change nothing until rst low.
REQ-037 pause=1 across 10 fall_tick pulses -> items_y, score, spawn counter unchanged; resume continues from frozen state.
REQ-038 All 4 slots active at spawn attempt -> attempt dropped; FALL_SPEEDUP_EN with score=32 -> y advances 6 per tick.
